// File: rtl/ic_fill_ctrl.sv
// Instruction-cache tag/valid lookup and line-fill controller.
// Direct-mapped tag/valid arrays, miss detection, 128-bit line fill sequencing and invalidation sweeps.
module ic_fill_ctrl #(
   parameter int IWIDTH = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:2]       pc_if,
   input  logic              ic_lookup_en,
   input  logic              fence_i,
   output logic              ic_req,
   output logic [31:4]       ic_req_adr,
   input  logic              ic_req_ack,
   input  logic              ic_rdat_m_valid,
   output logic [IWIDTH-3:0] ic_ram_wadr_all,
   output logic              ic_stall,
   output logic              ic_stall_dly,
   output logic              ic_stall_fin,
   output logic              ic_stall_fin2
);

   localparam int IDXW  = IWIDTH - 2;
   localparam int TAGW  = 30 - IWIDTH;
   localparam int NLINE = 1 << IDXW;

   typedef enum logic [2:0] {
      ST_FLUSH = 3'd0,
      ST_RUN   = 3'd1,
      ST_REQ   = 3'd2,
      ST_WAIT  = 3'd3,
      ST_FIN   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   cnt_q, cnt_d;
   logic              flush_pend_q, flush_pend_d;
   logic [31:4]       miss_adr_q, miss_adr_d;
   logic [IDXW-1:0]   wadr_q, wadr_d;
   logic              req_q, req_d;
   logic              stall_dly_q, stall_dly_d;
   logic              fin_q, fin_d;
   logic              fin2_q, fin2_d;
   logic [31:4]       lk_adr_q, lk_adr_d;
   logic              lk_vld_q, lk_vld_d;

   logic [TAGW-1:0]   tag_mem [NLINE];
   logic              vld_mem [NLINE];
   logic [TAGW-1:0]   tag_rd_q;
   logic              vld_rd_q;

   logic [IDXW-1:0]   rd_idx_s;
   logic [IDXW-1:0]   fill_idx_s;
   logic [TAGW-1:0]   fill_tag_s;
   logic              fill_we_s;
   logic              vld_we_s;
   logic [IDXW-1:0]   vld_widx_s;
   logic              vld_wdat_s;
   logic              miss_s;
   logic              unused_pc_s;

   assign unused_pc_s = ^pc_if[3:2];

   assign rd_idx_s   = pc_if[IWIDTH+1:4];
   assign fill_idx_s = miss_adr_q[IWIDTH+1:4];
   assign fill_tag_s = miss_adr_q[31:IWIDTH+2];
   assign fill_we_s  = (state_q == ST_WAIT) & ic_rdat_m_valid;
   // Sweep clears and fill writes never coincide: they belong to different states.
   assign vld_we_s   = (state_q == ST_FLUSH) | fill_we_s;
   assign vld_widx_s = (state_q == ST_FLUSH) ? cnt_q : fill_idx_s;
   assign vld_wdat_s = (state_q != ST_FLUSH);

   assign miss_s   = lk_vld_q & (state_q == ST_RUN) &
                     ~(vld_rd_q & (tag_rd_q == lk_adr_q[31:IWIDTH+2]));
   assign ic_stall = miss_s | (state_q != ST_RUN);

   // Tag/valid arrays with write-first synchronous read; contents are not reset.
   always_ff @(posedge clk) begin
      if (fill_we_s) begin
         tag_mem[fill_idx_s] <= fill_tag_s;
      end
      if (vld_we_s) begin
         vld_mem[vld_widx_s] <= vld_wdat_s;
      end
      tag_rd_q <= (fill_we_s && (fill_idx_s == rd_idx_s)) ? fill_tag_s : tag_mem[rd_idx_s];
      vld_rd_q <= (vld_we_s && (vld_widx_s == rd_idx_s)) ? vld_wdat_s : vld_mem[rd_idx_s];
   end

   // Next-state and next-output computation for the fill controller.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      flush_pend_d = flush_pend_q;
      miss_adr_d   = miss_adr_q;
      case (state_q)
         ST_FLUSH: begin
            if (fence_i) begin
               cnt_d = {IDXW{1'b0}};
            end else if (cnt_q == {IDXW{1'b1}}) begin
               cnt_d   = {IDXW{1'b0}};
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q + {{(IDXW-1){1'b0}}, 1'b1};
            end
         end
         ST_RUN: begin
            // A fence coinciding with a miss is remembered and honoured after the fill.
            if (miss_s) begin
               miss_adr_d   = lk_adr_q;
               flush_pend_d = flush_pend_q | fence_i;
               state_d      = ST_REQ;
            end else if (fence_i) begin
               cnt_d   = {IDXW{1'b0}};
               state_d = ST_FLUSH;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_REQ: begin
            flush_pend_d = flush_pend_q | fence_i;
            if (ic_req_ack) begin
               state_d = ST_WAIT;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_WAIT: begin
            flush_pend_d = flush_pend_q | fence_i;
            if (ic_rdat_m_valid) begin
               state_d = ST_FIN;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_FIN: begin
            if (flush_pend_q | fence_i) begin
               flush_pend_d = 1'b0;
               cnt_d        = {IDXW{1'b0}};
               state_d      = ST_FLUSH;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            flush_pend_d = 1'b0;
            cnt_d        = {IDXW{1'b0}};
            state_d      = ST_FLUSH;
         end
      endcase

      req_d       = (state_d == ST_REQ);
      fin_d       = (state_d == ST_FIN);
      fin2_d      = fin_q;
      stall_dly_d = ic_stall;
      wadr_d      = miss_adr_d[IWIDTH+1:4];
      lk_adr_d    = pc_if[31:4];
      lk_vld_d    = ic_lookup_en;
   end

   // Controller state, lookup pipeline and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_FLUSH;
         cnt_q        <= {IDXW{1'b0}};
         flush_pend_q <= 1'b0;
         miss_adr_q   <= 28'h000_0000;
         wadr_q       <= {IDXW{1'b0}};
         req_q        <= 1'b0;
         stall_dly_q  <= 1'b0;
         fin_q        <= 1'b0;
         fin2_q       <= 1'b0;
         lk_adr_q     <= 28'h000_0000;
         lk_vld_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         flush_pend_q <= flush_pend_d;
         miss_adr_q   <= miss_adr_d;
         wadr_q       <= wadr_d;
         req_q        <= req_d;
         stall_dly_q  <= stall_dly_d;
         fin_q        <= fin_d;
         fin2_q       <= fin2_d;
         lk_adr_q     <= lk_adr_d;
         lk_vld_q     <= lk_vld_d;
      end
   end

   assign ic_req          = req_q;
   assign ic_req_adr      = miss_adr_q;
   assign ic_ram_wadr_all = wadr_q;
   assign ic_stall_dly    = stall_dly_q;
   assign ic_stall_fin    = fin_q;
   assign ic_stall_fin2   = fin2_q;

endmodule

// File: tb/tb_ic_fill_ctrl.sv
// Bench for ic_fill_ctrl: directed scenarios plus randomized traffic checked
// every cycle against a behavioural cache/fill model.
module tb_ic_fill_ctrl;

   localparam int NL = 4096;
   localparam int P_FLUSH = 0, P_RUN = 1, P_REQ = 2, P_WAIT = 3, P_FIN = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:2] pc_if = 30'h0;
   logic        en = 1'b0, fence = 1'b0, ack = 1'b0, rv = 1'b0;
   logic        ic_req, ic_stall, ic_stall_dly, ic_stall_fin, ic_stall_fin2;
   logic [31:4] ic_req_adr;
   logic [11:0] ic_ram_wadr_all;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ic_fill_ctrl #(.IWIDTH(14)) dut (
      .clk(clk), .rst_n(rst_n), .pc_if(pc_if), .ic_lookup_en(en), .fence_i(fence),
      .ic_req(ic_req), .ic_req_adr(ic_req_adr), .ic_req_ack(ack),
      .ic_rdat_m_valid(rv), .ic_ram_wadr_all(ic_ram_wadr_all), .ic_stall(ic_stall),
      .ic_stall_dly(ic_stall_dly), .ic_stall_fin(ic_stall_fin), .ic_stall_fin2(ic_stall_fin2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: cache contents as plain arrays, fill progress as a phase.
   bit          m_valid [NL];
   logic [15:0] m_tag   [NL];
   int          m_phase, m_sweep;
   bit          m_pend, m_lkhit, m_lkvld, m_stall_prev, m_fin_prev;
   logic [31:4] m_madr, m_lkadr;

   task automatic model_step();
      bit miss, e_stall, e_fin;
      if (!rst_n) begin
         m_phase = P_FLUSH; m_sweep = 0; m_pend = 1'b0; m_madr = 28'h0; m_lkadr = 28'h0;
         m_lkvld = 1'b0; m_lkhit = 1'b0; m_stall_prev = 1'b0; m_fin_prev = 1'b0;
         return;
      end
      miss    = m_lkvld && (m_phase == P_RUN) && !m_lkhit;
      e_stall = miss || (m_phase != P_RUN);
      e_fin   = (m_phase == P_FIN);
      chk("m_stall", 32'(ic_stall), 32'(e_stall));
      chk("m_req", 32'(ic_req), 32'(m_phase == P_REQ));
      if (m_phase == P_REQ) chk("m_req_adr", 32'(ic_req_adr), 32'(m_madr));
      chk("m_wadr", 32'(ic_ram_wadr_all), 32'(m_madr[15:4]));
      chk("m_fin", 32'(ic_stall_fin), 32'(e_fin));
      chk("m_stall_dly", 32'(ic_stall_dly), 32'(m_stall_prev));
      chk("m_fin2", 32'(ic_stall_fin2), 32'(m_fin_prev));
      // this cycle's array updates are visible to this cycle's lookup
      if (m_phase == P_FLUSH) m_valid[m_sweep] = 1'b0;
      if (m_phase == P_WAIT && rv) begin
         m_valid[m_madr[15:4]] = 1'b1;
         m_tag[m_madr[15:4]]   = m_madr[31:16];
      end
      case (m_phase)
         P_FLUSH: begin
            if (fence) m_sweep = 0;
            else if (m_sweep == NL - 1) begin m_sweep = 0; m_phase = P_RUN; end
            else m_sweep++;
         end
         P_RUN: begin
            if (miss) begin m_madr = m_lkadr; m_phase = P_REQ; if (fence) m_pend = 1'b1; end
            else if (fence) begin m_sweep = 0; m_phase = P_FLUSH; end
         end
         P_REQ:  begin if (fence) m_pend = 1'b1; if (ack) m_phase = P_WAIT; end
         P_WAIT: begin if (fence) m_pend = 1'b1; if (rv) m_phase = P_FIN; end
         default: begin
            if (m_pend || fence) begin m_pend = 1'b0; m_sweep = 0; m_phase = P_FLUSH; end
            else m_phase = P_RUN;
         end
      endcase
      m_lkhit      = m_valid[pc_if[15:4]] && (m_tag[pc_if[15:4]] == pc_if[31:16]);
      m_lkvld      = en;
      m_lkadr      = pc_if[31:4];
      m_stall_prev = e_stall;
      m_fin_prev   = e_fin;
   endtask

   initial begin
      for (int i = 0; i < NL; i++) begin m_valid[i] = 1'b0; m_tag[i] = 16'h0; end
      forever begin
         @(negedge clk);
         model_step();
      end
   end

   // One cycle: drive inputs just after the edge, return at the following negedge.
   task automatic cyc(input logic [31:2] p, input logic e, input logic f, input logic a, input logic r);
      @(posedge clk);
      #1;
      pc_if = p; en = e; fence = f; ack = a; rv = r;
      @(negedge clk);
   endtask

   task automatic fill(input logic [31:2] p, input logic [31:4] exp_adr, input string nm);
      cyc(p, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(p, 1'b1, 1'b0, 1'b0, 1'b0);
      chk({nm, "_miss"}, 32'(ic_stall), 32'd1);
      cyc(p, 1'b1, 1'b0, 1'b1, 1'b0);
      chk({nm, "_req"}, 32'(ic_req), 32'd1);
      chk({nm, "_req_adr"}, 32'(ic_req_adr), 32'(exp_adr));
      cyc(p, 1'b1, 1'b0, 1'b0, 1'b1);
      chk({nm, "_wait_noreq"}, 32'(ic_req), 32'd0);
      cyc(p, 1'b1, 1'b0, 1'b0, 1'b0);
      chk({nm, "_fin"}, 32'(ic_stall_fin), 32'd1);
      cyc(p, 1'b1, 1'b0, 1'b0, 1'b0);
      chk({nm, "_unstall"}, 32'(ic_stall), 32'd0);
      chk({nm, "_fin2"}, 32'(ic_stall_fin2), 32'd1);
   endtask

   task automatic count_flush(input int fence_at, output int n);
      n = 0;
      for (int k = 0; k < 6000; k++) begin
         cyc(30'h0, 1'b0, (k == fence_at), 1'b0, 1'b0);
         if (!ic_stall) break;
         n++;
      end
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int n;
      logic [11:0] idx_pool [4];
      logic [15:0] t;
      logic [11:0] ix;
      idx_pool = '{12'h010, 12'h011, 12'h020, 12'h030};

      repeat (3) @(negedge clk);
      chk("rst_stall", 32'(ic_stall), 32'd1);
      chk("rst_req", 32'(ic_req), 32'd0);
      chk("rst_req_adr", 32'(ic_req_adr), 32'd0);
      chk("rst_wadr", 32'(ic_ram_wadr_all), 32'd0);
      chk("rst_fin", 32'(ic_stall_fin), 32'd0);
      chk("rst_fin2", 32'(ic_stall_fin2), 32'd0);
      chk("rst_dly", 32'(ic_stall_dly), 32'd0);

      @(posedge clk);
      #1 rst_n = 1'b1;
      n = 0;
      @(negedge clk);
      while (ic_stall && n < 5000) begin n++; @(negedge clk); end
      chk("reset_sweep_len", n, 32'd4096);

      // Cold miss on 0x100, ack at once, line returns three cycles later.
      cyc(30'h40, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(30'h40, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("cold_miss_stall", 32'(ic_stall), 32'd1);
      cyc(30'h40, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("cold_req", 32'(ic_req), 32'd1);
      chk("cold_req_adr", 32'(ic_req_adr), 32'h10);
      chk("cold_wadr", 32'(ic_ram_wadr_all), 32'h010);
      cyc(30'h40, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(30'h40, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(30'h40, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("cold_fin_early", 32'(ic_stall_fin), 32'd0);
      cyc(30'h40, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("cold_fin", 32'(ic_stall_fin), 32'd1);
      chk("cold_fin_stall", 32'(ic_stall), 32'd1);
      cyc(30'h40, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("cold_unstall", 32'(ic_stall), 32'd0);
      chk("cold_fin2", 32'(ic_stall_fin2), 32'd1);
      chk("cold_fin_once", 32'(ic_stall_fin), 32'd0);
      for (int k = 0; k < 3; k++) begin
         cyc(30'h40, 1'b1, 1'b0, 1'b0, 1'b0);
         chk("refetch_hit_noreq", 32'(ic_req), 32'd0);
         chk("refetch_hit_nostall", 32'(ic_stall), 32'd0);
      end

      // Ack withheld for five cycles on 0x200.
      cyc(30'h80, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(30'h80, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         cyc(30'h80, 1'b1, 1'b0, 1'b0, 1'b0);
         chk("hold_req", 32'(ic_req), 32'd1);
         chk("hold_req_adr", 32'(ic_req_adr), 32'h20);
         chk("hold_wadr", 32'(ic_ram_wadr_all), 32'h020);
      end
      cyc(30'h80, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("hold_req_ack", 32'(ic_req), 32'd1);
      cyc(30'h80, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("hold_wait", 32'(ic_req), 32'd0);
      cyc(30'h80, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("hold_fin", 32'(ic_stall_fin), 32'd1);

      // Conflict on index 0x010: tag 1 evicts tag 0, which then misses again.
      fill(30'h0000_4040, 28'h000_1010, "conflict_t1");
      fill(30'h0000_0040, 28'h000_0010, "conflict_t0");

      // fence_i during WAIT: fill completes, then a full sweep.
      cyc(30'hC0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(30'hC0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("fence_miss", 32'(ic_stall), 32'd1);
      cyc(30'hC0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("fence_req_adr", 32'(ic_req_adr), 32'h30);
      cyc(30'hC0, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(30'hC0, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc(30'hC0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("fence_fin", 32'(ic_stall_fin), 32'd1);
      count_flush(-1, n);
      chk("fence_sweep_len", n, 32'd4096);

      // Spurious line-valid in RUN must not validate the flushed 0x300 line.
      cyc(30'hC0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("spurious_fin0", 32'(ic_stall_fin), 32'd0);
      cyc(30'hC0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("spurious_fin1", 32'(ic_stall_fin), 32'd0);
      fill(30'hC0, 28'h30, "after_spurious");
      fill(30'h40, 28'h10, "after_fence");

      // Randomized traffic over a small set of lines and tags.
      for (int k = 0; k < 3000; k++) begin
         t  = 16'($urandom_range(0, 2));
         ix = idx_pool[$urandom_range(0, 3)];
         cyc({t, ix, 2'($urandom_range(0, 3))}, ($urandom_range(0, 7) != 0),
             1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end
      for (int k = 0; k < 20; k++) begin
         cyc(30'h0, 1'b0, 1'b0, 1'b1, 1'b1);
         if (!ic_stall) break;
      end
      chk("drain_idle", 32'(ic_stall), 32'd0);

      // fence_i in RUN, restarted by a second fence 100 cycles into the sweep.
      cyc(30'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      count_flush(100, n);
      chk("restart_sweep_len", n, 32'd4197);
      fill(30'h40, 28'h10, "after_restart");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ic_fill_ctrl.md
# ic_fill_ctrl

Instruction-cache tag/valid lookup and line-fill controller feeding the IF stage. Checks every fetch address against a direct-mapped tag array and, on a miss, stalls fetch and issues a 128-bit line read to the DRAM bus. It then steers the returning line into the instruction RAM and produces the `ic_stall*` sequencing the IF stage consumes. It also runs the post-reset and `fence.i` invalidation sweeps.

## Interface
- `IWIDTH`, 14: instruction RAM word-address width.
  - Line index is `pc[IWIDTH+1:4]`, giving `IWIDTH-2` bits and 2^(IWIDTH-2) lines of 4 words.
  - Tag is `pc[31:IWIDTH+2]`, giving `30-IWIDTH` bits.
- Clock and reset: reset `rst_n`, asynchronous, active-low; clock `clk`.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `pc_if` in [31:2]: current fetch address; the same value addresses the instruction RAM.
- `ic_lookup_en` in 1: fetch valid this cycle. Low during monitor reads, `pc_start` and pipe reset.
- `fence_i` in 1: one-cycle pulse requesting full invalidation.
- `ic_req` out 1: line read request.
- `ic_req_adr` out [31:4]: line address of the request.
- `ic_req_ack` in 1: request accepted.
- `ic_rdat_m_valid` in 1: the returning 128-bit line is valid this cycle. The data goes directly to the instruction RAM.
- `ic_ram_wadr_all` out [IWIDTH-3:0]: line index to write in the instruction RAM.
- `ic_stall` out 1: fetch stall.
- `ic_stall_dly` out 1: `ic_stall` delayed one cycle.
- `ic_stall_fin` out 1: one-cycle pulse, first cycle after the line is written.
- `ic_stall_fin2` out 1: `ic_stall_fin` delayed one cycle.

## Operation
- Storage:
  - Tag RAM: 2^(IWIDTH-2) × (30-IWIDTH) bits, synchronous read.
  - Valid array: 2^(IWIDTH-2) × 1 bit, synchronous read.
  - Neither array is reset.
- Lookup pipeline:
  - Cycle t: read both arrays at `pc_if` index; register `lk_adr <= pc_if` and `lk_vld <= ic_lookup_en`.
  - Cycle t+1: `miss = lk_vld & state==RUN & ~(valid_rd & tag_rd == lk_adr tag)`.
  - A read and write to the same index in the same cycle returns the new value (write-first).
- States:
  - **FLUSH**: a sweep counter clears one valid bit per cycle, from index 0 to 2^(IWIDTH-2)-1. After the last index, go to RUN.
  - **RUN**: on `miss`, latch `miss_adr <= lk_adr[31:4]` and go to REQ. On `fence_i`, go to FLUSH with the counter at 0.
  - **REQ**: `ic_req=1`, `ic_req_adr=miss_adr`, both held stable. If `ic_req_ack` is high at the edge, go to WAIT.
  - **WAIT**: on `ic_rdat_m_valid`, write tag = `miss_adr` tag and valid = 1 at the `miss_adr` index, then go to FIN.
  - **FIN**: one cycle. Go to FLUSH if a flush is pending, else RUN.
- `ic_ram_wadr_all` is always `miss_adr[IWIDTH+1:4]`, registered. It is stable from REQ through FIN.
- `ic_stall = miss | state ∈ {FLUSH, REQ, WAIT, FIN}`. In RUN the `miss` term is combinational, so the IF stage holds its PC in the detect cycle.
- `ic_stall_fin = (state==FIN)`. `ic_stall_dly` and `ic_stall_fin2` are plain flops.
- A `fence_i` arriving in REQ or WAIT sets `flush_pend`. It takes effect after FIN; the fill completes first and is then invalidated by the sweep.
- A `fence_i` arriving in FLUSH restarts the counter at 0.
- `ic_rdat_m_valid` outside WAIT is ignored and causes no writes.
- Jumps and `rst_pipe` do not cancel an outstanding fill. The fill completes, and the next lookup re-evaluates the redirected PC.

## Timing
- Reset values:
  - State FLUSH, counter 0.
  - `ic_req`, `ic_stall_dly`, `ic_stall_fin`, `ic_stall_fin2`, `flush_pend`, `lk_vld`: 0.
  - `ic_ram_wadr_all`, `miss_adr`: 0.
  - `ic_stall` = 1 (state FLUSH).
- Post-reset sweep: `ic_stall` is high for exactly 2^(IWIDTH-2) cycles, which is 4096 at the default.
- Miss sequence:
  - Address presented at cycle t; miss and `ic_stall` asserted at t+1; `ic_req` asserted from t+2.
  - With ack at cycle a, WAIT starts at a+1.
  - `ic_rdat_m_valid` at cycle v performs the write at v; FIN at v+1; `ic_stall` low and `ic_stall_fin2` high at v+2.
- Minimum miss penalty, with ack at t+2 and valid at t+3: `ic_stall` high for cycles t+1 through t+4.
- The lookup of the refetched PC made in FIN hits, because of the write-first rule.

## Test plan
- Reset with IWIDTH=14: `ic_stall` high for 4096 cycles, then low. First fetch of `pc_if=0x100>>2` → miss, `ic_req=1`, `ic_req_adr=0x10`.
- Cold miss with ack at once and valid 3 cycles later: `ic_ram_wadr_all=0x010`, one-cycle `ic_stall_fin` at valid+1, `ic_stall_fin2` at valid+2. Refetch of 0x100 hits, with no second `ic_req`.
- `ic_req_ack` held low for 5 cycles: `ic_req` and `ic_req_adr` stay constant for all 5 cycles, and no state advance occurs.
- Conflict: fill 0x0000_0100, then fetch 0x0001_0100 (same index, tag 0x0001) → miss. After its fill, 0x100 misses again.
- `fence_i` during WAIT: fill completes and FIN pulses, then a 4096-cycle FLUSH. The next fetch of 0x100 misses.
- Spurious `ic_rdat_m_valid` in RUN: no tag write, `ic_stall_fin` stays 0, and a prior miss on that index still misses.
